// File: rtl/seg_bcd_counter.sv
// Multi-digit packed-BCD counter for the seven-segment driver.
// Prescaled stepping, up/down, clear/load, and a runtime wrap limit.
module seg_bcd_counter #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 2,
  parameter int DIGITS   = 6
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  run,
  input  logic                  dir,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   limit,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  tick,
  output logic                  wrap,
  output logic                  err
);

  localparam int W   = 4 * DIGITS;
  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

  logic [W-1:0]  r_bcd;
  logic [PW-1:0] r_p;
  logic          r_tick;
  logic          r_wrap;
  logic          r_err;

  logic [W-1:0]  w_inc;
  logic [W-1:0]  w_dec;
  logic          w_cy;
  logic          w_bw;
  logic          w_ok;
  logic          w_last;

  assign w_last = (r_p == P_LAST);

  // Ripple carry/borrow across digits; also validate load nibbles.
  always_comb begin
    w_inc = r_bcd;
    w_dec = r_bcd;
    w_cy  = 1'b1;
    w_bw  = 1'b1;
    w_ok  = (load_val <= limit);
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) w_ok = 1'b0;
      if (w_cy) begin
        if (r_bcd[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
          w_cy = 1'b0;
        end
      end
      if (w_bw) begin
        if (r_bcd[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_bcd[4*i +: 4] - 4'd1;
          w_bw = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bcd  <= '0;
      r_p    <= '0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
      if (clr) begin
        r_bcd <= '0;
        r_p   <= '0;
      end else if (load) begin
        if (w_ok) begin
          r_bcd <= load_val;
          r_p   <= '0;
        end else begin
          r_err <= 1'b1;
        end
      end else if (run) begin
        if (w_last) begin
          r_p    <= '0;
          r_tick <= 1'b1;
          if (!dir) begin
            if (r_bcd >= limit) begin
              r_bcd  <= '0;
              r_wrap <= 1'b1;
            end else begin
              r_bcd <= w_inc;
            end
          end else if (r_bcd == '0) begin
            r_bcd  <= limit;
            r_wrap <= 1'b1;
          end else begin
            r_bcd <= w_dec;
          end
        end else begin
          r_p <= r_p + PW'(1);
        end
      end
    end
  end

  assign bcd_out = r_bcd;
  assign tick    = r_tick;
  assign wrap    = r_wrap;
  assign err     = r_err;

endmodule

// File: tb/tb_seg_bcd_counter.sv
// Bench for seg_bcd_counter: DIV=10, two digits, decimal reference model.
// Directed scenarios followed by a randomized run.
module tb_seg_bcd_counter;

  localparam int DIV = 10;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       dir;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] limit;
  logic [7:0] bcd_out;
  logic       tick;
  logic       wrap;
  logic       err;

  int checks = 0;
  int errors = 0;

  int m_val;
  int m_p;
  bit m_tick;
  bit m_wrap;
  bit m_err;

  logic [10:0] w_obs;
  assign w_obs = {bcd_out, tick, wrap, err};

  seg_bcd_counter #(
    .CLK_FREQ(10),
    .TICK_HZ (1),
    .DIGITS  (2)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .run      (run),
    .dir      (dir),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .bcd_out  (bcd_out),
    .tick     (tick),
    .wrap     (wrap),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bcd2dec(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] dec2bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic logic [10:0] exp_vec();
    return {dec2bcd(m_val), m_tick, m_wrap, m_err};
  endfunction

  task automatic model_clear();
    m_val  = 0;
    m_p    = 0;
    m_tick = 0;
    m_wrap = 0;
    m_err  = 0;
  endtask

  // One clock: the model takes the same sampled inputs as the DUT.
  task automatic cyc();
    int lim;
    @(posedge clk);
    lim = bcd2dec(limit);
    if (!rst_n) begin
      model_clear();
    end else begin
      m_tick = 0;
      m_wrap = 0;
      m_err  = 0;
      if (clr) begin
        m_val = 0;
        m_p   = 0;
      end else if (load) begin
        if (load_val[3:0] <= 9 && load_val[7:4] <= 9 &&
            bcd2dec(load_val) <= lim) begin
          m_val = bcd2dec(load_val);
          m_p   = 0;
        end else begin
          m_err = 1;
        end
      end else if (run) begin
        if (m_p == DIV - 1) begin
          m_p    = 0;
          m_tick = 1;
          if (!dir) begin
            if (m_val >= lim) begin
              m_val  = 0;
              m_wrap = 1;
            end else begin
              m_val = m_val + 1;
            end
          end else if (m_val == 0) begin
            m_val  = lim;
            m_wrap = 1;
          end else begin
            m_val = m_val - 1;
          end
        end else begin
          m_p = m_p + 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v);
    load     = 1'b1;
    load_val = v;
    cyc();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    run      = 1'b1;
    dir      = 1'b0;
    clr      = 1'b0;
    load     = 1'b0;
    load_val = 8'h00;
    limit    = 8'h59;
    model_clear();
    #1;
    checks++;
    if (w_obs !== 11'h0) begin
      errors++;
      $display("FAIL reset_immediate: got %h expected %h", w_obs, 11'h0);
    end
    cyc();
    cyc();
    checks++;
    if (w_obs !== 11'h0) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", w_obs, 11'h0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    for (int i = 1; i <= 100; i++) begin
      cyc();
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++;
        $display("FAIL free_run cyc %0d: got %h expected %h",
                 i, w_obs, exp_vec());
      end
      if (i == 9 || i == 10 || i == 11) begin
        checks++;
        if ({bcd_out, tick} !== ((i == 10) ? 9'h003 : (i == 9) ? 9'h000 : 9'h002)) begin
          errors++;
          $display("FAIL first_step cyc %0d: got %h/%b", i, bcd_out, tick);
        end
      end
    end
    checks++;
    if (bcd_out !== 8'h10) begin
      errors++;
      $display("FAIL digit_carry: got %h expected 10", bcd_out);
    end
  endtask

  task automatic test_wrap_up();
    for (int i = 1; i <= 500; i++) begin
      cyc();
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++;
        $display("FAIL wrap_run cyc %0d: got %h expected %h",
                 i, w_obs, exp_vec());
      end
      if (i == 490) begin
        checks++;
        if (bcd_out !== 8'h59) begin
          errors++;
          $display("FAIL reach_59: got %h expected 59", bcd_out);
        end
      end
    end
    checks++;
    if ({bcd_out, tick, wrap} !== 10'h003) begin
      errors++;
      $display("FAIL wrap_59: got %h/%b/%b expected 00/1/1",
               bcd_out, tick, wrap);
    end
    cyc();
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_width: got %b expected 0", wrap);
    end
    do_load(8'h35);
    limit = 8'h20;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++;
        $display("FAIL limit_run cyc %0d: got %h expected %h",
                 i, w_obs, exp_vec());
      end
    end
    checks++;
    if ({bcd_out, wrap} !== 9'h001) begin
      errors++;
      $display("FAIL limit_wrap: got %h/%b expected 00/1", bcd_out, wrap);
    end
    limit = 8'h59;
  endtask

  task automatic test_down();
    dir = 1'b1;
    do_load(8'h10);
    repeat (10) cyc();
    checks++;
    if ({bcd_out, tick, wrap} !== 10'h026) begin
      errors++;
      $display("FAIL down_borrow: got %h/%b/%b expected 09/1/0",
               bcd_out, tick, wrap);
    end
    do_load(8'h00);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++;
        $display("FAIL down_run cyc %0d: got %h expected %h",
                 i, w_obs, exp_vec());
      end
    end
    checks++;
    if ({bcd_out, wrap} !== 9'hB3) begin
      errors++;
      $display("FAIL down_wrap: got %h/%b expected 59/1", bcd_out, wrap);
    end
    dir = 1'b0;
  endtask

  task automatic test_pause();
    do_load(8'h25);
    repeat (4) cyc();
    run = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      cyc();
      checks++;
      if ({bcd_out, tick} !== 9'h04A) begin
        errors++;
        $display("FAIL pause_hold cyc %0d: got %h/%b expected 25/0",
                 i, bcd_out, tick);
      end
    end
    run = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      checks++;
      if ({bcd_out, tick} !== ((i == 6) ? 9'h04D : 9'h04A)) begin
        errors++;
        $display("FAIL pause_resume cyc %0d: got %h/%b", i, bcd_out, tick);
      end
    end
  endtask

  task automatic test_load_clear();
    do_load(8'h37);
    checks++;
    if ({bcd_out, err} !== 9'h06E) begin
      errors++;
      $display("FAIL load_37: got %h/%b expected 37/0", bcd_out, err);
    end
    do_load(8'h3A);
    checks++;
    if ({bcd_out, err} !== 9'h06F) begin
      errors++;
      $display("FAIL load_3A: got %h/%b expected 37/1", bcd_out, err);
    end
    cyc();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_width: got %b expected 0", err);
    end
    do_load(8'h60);
    checks++;
    if ({bcd_out, err} !== 9'h06F) begin
      errors++;
      $display("FAIL load_60: got %h/%b expected 37/1", bcd_out, err);
    end
    for (int i = 0; i < 2 * DIV && m_p != DIV - 1; i++) cyc();
    checks++;
    if (m_p != DIV - 1 || w_obs !== exp_vec()) begin
      errors++;
      $display("FAIL reach_p9: got %h expected %h p %0d",
               w_obs, exp_vec(), m_p);
    end
    clr = 1'b1;
    do_load(8'h12);
    clr = 1'b0;
    checks++;
    if (w_obs !== 11'h000) begin
      errors++;
      $display("FAIL clr_load: got %h expected 000", w_obs);
    end
    for (int i = 1; i <= 10; i++) begin
      cyc();
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++;
        $display("FAIL after_clr cyc %0d: got %h expected %h",
                 i, w_obs, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    do_load(8'h42);
    repeat (3) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if (w_obs !== 11'h0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 000", w_obs);
    end
    cyc();
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++;
        $display("FAIL post_reset cyc %0d: got %h expected %h",
                 i, w_obs, exp_vec());
      end
    end
    checks++;
    if ({bcd_out, tick} !== 9'h003) begin
      errors++;
      $display("FAIL post_reset_step: got %h/%b expected 01/1",
               bcd_out, tick);
    end
  endtask

  task automatic test_random();
    for (int i = 1; i <= 1500; i++) begin
      run      = ($urandom % 8) != 0;
      clr      = ($urandom % 60) == 0;
      load     = ($urandom % 20) == 0;
      load_val = 8'($urandom);
      if ($urandom % 40 == 0) dir = ~dir;
      if ($urandom % 150 == 0) limit = dec2bcd(int'($urandom % 100));
      cyc();
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d: got %h expected %h",
                 i, w_obs, exp_vec());
      end
    end
    clr  = 1'b0;
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_wrap_up();
    test_down();
    test_pause();
    test_load_clear();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_bcd_counter.md
# seg_bcd_counter

Parametrised multi-digit BCD counter that produces the packed display value for the seven-segment driver (`seg_led`). It replaces hard-coded per-count value tables in top-level modules with a generic counter. It supports:
- programmable tick rate and digit count;
- up/down counting with run/pause;
- synchronous clear and load;
- a runtime wrap limit.

It sits between the system clock domain and the `data` input of `seg_led`, typically zero-extended to the driver width.

## Interface
- CLK_FREQ, 50_000_000, input clock frequency in Hz
- TICK_HZ, 2, count rate in Hz; prescaler divisor DIV = CLK_FREQ/TICK_HZ, DIV >= 2 required
- DIGITS, 6, number of BCD digits, 1..8; W = 4*DIGITS
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- run  in  1  1 = prescaler advances and counter steps; 0 = pause, all state held
- dir  in  1  0 = count up, 1 = count down; sampled on the step edge
- clr  in  1  synchronous clear of counter and prescaler
- load  in  1  synchronous load request
- load_val  in  W  packed BCD value to load, digit 0 in [3:0]
- limit  in  W  packed BCD maximum count (wrap point)
- bcd_out  out  W  current count, packed BCD, registered
- tick  out  1  one-cycle pulse, coincident with each step
- wrap  out  1  one-cycle pulse when a step wraps
- err  out  1  one-cycle pulse when a load is rejected

## Operation
- **Reset state:** while sys_rst_n = 0, all outputs and state are cleared immediately:
  - bcd_out = 0, tick = 0, wrap = 0, err = 0;
  - prescaler p = 0.
- **Prescaler:** p counts 0..DIV-1 while run = 1 and holds its value while run = 0, so pausing preserves the phase. A step occurs on the edge where run = 1 and p = DIV-1; on that edge p returns to 0.
- **Priority each edge:** clr > load > step > hold.
- **clr:**
  - bcd_out <= 0 and p <= 0;
  - tick, wrap and err stay 0;
  - any simultaneous load or step is discarded.
- **load:**
  - Accepted when every nibble of load_val is <= 9 and load_val <= limit. Then bcd_out <= load_val and p <= 0.
  - Otherwise bcd_out and p are unchanged and err pulses.
  - A step due on the same edge is discarded; tick is not asserted.
- **Step up (dir = 0):**
  - If bcd_out >= limit: bcd_out <= 0 and wrap pulses.
  - Else BCD increment: a digit at 9 goes to 0 and carries into the next digit.
- **Step down (dir = 1):**
  - If bcd_out = 0: bcd_out <= limit and wrap pulses.
  - Else BCD decrement: a digit at 0 goes to 9 and borrows from the next digit.
- **Comparison:** compare packed BCD values as unsigned W-bit binary; nibble packing preserves ordering.
- **Limit changed at runtime:**
  - Counting up with bcd_out > limit: the next step wraps to 0.
  - Counting down with bcd_out > limit: decrement normally.
- **Invalid limit:** a limit with a nibble > 9 is a caller error; behaviour is defined only by the compare rules above.
- **Status pulses:** tick, wrap and err are single-cycle and registered; they deassert on the following edge unless re-triggered.

## Timing
- All outputs are registered. The new bcd_out, tick and wrap become visible together in the cycle after the step edge.
- With run held at 1 from reset release, the first step edge is the DIV-th rising edge; subsequent steps follow every DIV cycles.
- Pausing for N cycles delays the next step by exactly N cycles.
- clr/load latency: bcd_out reflects the new value one cycle after the edge that sampled the request. The next step then occurs DIV run-cycles later.
- Reset asserted mid-period: outputs clear asynchronously. After release, counting restarts from p = 0.
- dir change takes effect on the next step edge; no extra latency.

## Test plan
Bench parameters: CLK_FREQ=10, TICK_HZ=1 (DIV=10), DIGITS=2, limit=0x59.

1. **Free-running up count:** release reset with run=1, dir=0.
   - bcd_out goes 0x00 -> 0x01 at the 10th edge, and tick pulses for 1 cycle every 10 cycles.
   - 0x09 steps to 0x10 (digit carry).
2. **Wrap up / runtime limit:**
   - From 0x59, the next step gives 0x00 with wrap=1 for exactly 1 cycle, coincident with tick.
   - Set limit=0x20 while bcd_out=0x35: the next step gives 0x00 with wrap=1.
3. **Down count:** dir=1.
   - From 0x10, the step gives 0x09.
   - From 0x00, the step gives 0x59 with wrap=1.
4. **Pause:** drop run at p=4 for 7 cycles, then restore.
   - bcd_out is held throughout.
   - The next step occurs 6 run-cycles after resume, i.e. 13 cycles after the pause began.
5. **Load / clear:**
   - load 0x37: bcd_out=0x37 next cycle and p=0.
   - load 0x3A: err=1 for 1 cycle, value unchanged.
   - load 0x60: err=1, value unchanged.
   - clr and load together at p=9: bcd_out=0x00, no tick, no err.
6. **Async reset:** assert sys_rst_n=0 mid-period at bcd_out=0x42.
   - Outputs go 0 without a clock edge.
   - After release, the first step comes at the 10th edge, giving 0x01.
